// File: rtl/pipe_mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, one bit per cycle,
// with the interlock that holds IF/ID/EX while a later HI/LO user waits.
module pipe_mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             estart,
    input  logic [1:0]       eop,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic             ewhi,
    input  logic             ewlo,
    input  logic             erdhl,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             mdu_stall
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rawa_q, rawa_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               aneg_q, aneg_d;
    logic               zero_q, zero_d;

    logic               sgn;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     dshift;
    logic [WIDTH:0]     ddiff;
    logic               dge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign busy      = (state_q != S_IDLE);
    assign mdu_stall = busy & (estart | ewhi | ewlo | erdhl);
    assign hi        = hi_q;
    assign lo        = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        rawa_d  = rawa_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        neg_d   = neg_q;
        aneg_d  = aneg_q;
        zero_d  = zero_q;

        sgn   = ~eop[0];
        abs_a = (sgn & ea[WIDTH-1]) ? -ea : ea;
        abs_b = (sgn & eb[WIDTH-1]) ? -eb : eb;

        // Multiply: acc = {partial, multiplier}; add on LSB, then shift right.
        msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};

        // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
        dshift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ddiff  = dshift - {1'b0, b_q};
        dge    = (dshift >= {1'b0, b_q});

        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = aneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                      : acc_q[2*WIDTH-1:WIDTH];

        unique case (state_q)
            S_IDLE: begin
                if (estart) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_MAX;
                    div_d   = eop[1];
                    neg_d   = sgn & (ea[WIDTH-1] ^ eb[WIDTH-1]);
                    aneg_d  = sgn & ea[WIDTH-1];
                    zero_d  = (eb == '0);
                    rawa_d  = ea;
                    if (eop[1]) begin
                        acc_d = {{WIDTH{1'b0}}, abs_a};
                        b_d   = abs_b;
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, abs_b};
                        b_d   = abs_a;
                    end
                end else begin
                    if (ewhi) hi_d = ea;
                    if (ewlo) lo_d = ea;
                end
            end
            S_RUN: begin
                if (div_q) begin
                    acc_d = {(dge ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], dge};
                end else begin
                    acc_d = {msum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) state_d = S_FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!div_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (zero_q) begin
                    hi_d = rawa_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            rawa_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            aneg_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            rawa_q  <= rawa_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            aneg_q  <= aneg_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_pipe_mdu_seq.sv
// Randomized bench for pipe_mdu_seq against an arithmetic HI/LO model,
// plus directed latency, interlock, MTHI/MTLO and reset cases.
module tb_pipe_mdu_seq;

    logic        clock;
    logic        resetn;
    logic        estart;
    logic [1:0]  eop;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ewhi;
    logic        ewlo;
    logic        erdhl;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        mdu_stall;

    int n_checks = 0;
    int n_errors = 0;

    pipe_mdu_seq #(.WIDTH(32)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .estart    (estart),
        .eop       (eop),
        .ea        (ea),
        .eb        (eb),
        .ewhi      (ewhi),
        .ewlo      (ewlo),
        .erdhl     (erdhl),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .mdu_stall (mdu_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] h,
                                  output logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] p, tq, tr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = 32'h0;
        l = 32'h0;
        case (op)
            2'd0: begin
                p = sa * sb;
                h = p[63:32];
                l = p[31:0];
            end
            2'd1: begin
                p = {32'h0, a} * {32'h0, b};
                h = p[63:32];
                l = p[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else if (op == 2'd2) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    tq = q;
                    tr = r;
                    l  = tq[31:0];
                    h  = tr[31:0];
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit hold_rd,
                         input bit with_mt);
        logic [31:0] eh, el, h0, l0;
        int          cyc, stl;
        bit          held;
        model(op, a, b, eh, el);
        @(negedge clock);
        check("idle_busy", {63'h0, busy}, 64'h0);
        h0 = hi;
        l0 = lo;
        estart = 1'b1;
        eop    = op;
        ea     = a;
        eb     = b;
        ewhi   = with_mt;
        ewlo   = with_mt;
        @(negedge clock);
        estart = 1'b0;
        ewhi   = 1'b0;
        ewlo   = 1'b0;
        ea     = $urandom;
        eb     = $urandom;
        erdhl  = hold_rd;
        #1;
        cyc  = 0;
        stl  = 0;
        held = 1'b1;
        while (busy && cyc < 100) begin
            cyc++;
            if (mdu_stall) stl++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            @(negedge clock);
            #1;
        end
        check("busy_cycles", 64'(cyc), 64'd33);
        check("stall_cycles", 64'(stl), hold_rd ? 64'd33 : 64'd0);
        check("hilo_held", {63'h0, held}, 64'h1);
        check("stall_released", {63'h0, mdu_stall}, 64'h0);
        check("hi", {32'h0, hi}, {32'h0, eh});
        check("lo", {32'h0, lo}, {32'h0, el});
        erdhl = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int cyc, stl;
        resetn = 1'b0;
        estart = 1'b0;
        eop    = 2'd0;
        ea     = 32'h0;
        eb     = 32'h0;
        ewhi   = 1'b0;
        ewlo   = 1'b0;
        erdhl  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_hi", {32'h0, hi}, 64'h0);
        check("rst_lo", {32'h0, lo}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        resetn = 1'b1;

        // Stall only while busy: MFHI/MFLO in IDLE passes straight through.
        @(negedge clock);
        erdhl = 1'b1;
        #1;
        check("idle_nostall", {63'h0, mdu_stall}, 64'h0);
        erdhl = 1'b0;

        issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
        issue(2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        issue(2'd3, 32'd100, 32'd7, 1'b1, 1'b0);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(2'd3, 32'd5, 32'd0, 1'b0, 1'b0);
        issue(2'd2, 32'hFFFF_FFF7, 32'd0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // MTLO in IDLE.
        @(negedge clock);
        ewlo = 1'b1;
        ea   = 32'h0000_1234;
        @(negedge clock);
        ewlo = 1'b0;
        check("mtlo", {32'h0, lo}, 64'h1234);
        check("mtlo_busy", {63'h0, busy}, 64'h0);

        // MTHI while busy stalls until IDLE, then lands.
        @(negedge clock);
        estart = 1'b1;
        eop    = 2'd1;
        ea     = 32'd3;
        eb     = 32'd5;
        @(negedge clock);
        estart = 1'b0;
        ewhi   = 1'b1;
        ea     = 32'hCAFE_0001;
        #1;
        cyc = 0;
        stl = 0;
        while (mdu_stall && cyc < 100) begin
            cyc++;
            stl++;
            @(negedge clock);
            #1;
        end
        check("mthi_stall", 64'(stl), 64'd33);
        check("mthi_pre_hi", {32'h0, hi}, 64'h0);
        check("mthi_pre_lo", {32'h0, lo}, 64'd15);
        @(negedge clock);
        ewhi = 1'b0;
        check("mthi_post", {32'h0, hi}, 64'hCAFE_0001);

        // Reset mid-RUN with counter at 10.
        @(negedge clock);
        estart = 1'b1;
        eop    = 2'd0;
        ea     = 32'h1234_5678;
        eb     = 32'h9ABC_DEF0;
        @(negedge clock);
        estart = 1'b0;
        repeat (21) @(negedge clock);
        erdhl  = 1'b1;
        resetn = 1'b0;
        #1;
        check("mid_rst_hi", {32'h0, hi}, 64'h0);
        check("mid_rst_lo", {32'h0, lo}, 64'h0);
        check("mid_rst_busy", {63'h0, busy}, 64'h0);
        check("mid_rst_stall", {63'h0, mdu_stall}, 64'h0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (40) @(negedge clock);
        check("post_rst_busy", {63'h0, busy}, 64'h0);
        check("post_rst_hi", {32'h0, hi}, 64'h0);
        check("post_rst_lo", {32'h0, lo}, 64'h0);
        erdhl = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
